seg7_scan_driver: RTL and testbench

- Time-multiplexed seven-segment display driver; consumes the packed BCD digits produced by the binary-to-BCD converter stage and drives the board's common-anode digit array.
- Double-buffers the incoming value and commits it only at a scan-frame boundary, so the display never tears.
- Decodes each digit, blanks leading zeros when enabled, and rotates one active anode every REFRESH_DIV cycles.

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_decode.sv | 26 ++
 rtl/seg7_scan_driver.sv | 119 +++++++++++
 tb/tb_seg7_scan_driver.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the seven-segment scan driver.
// Segment vectors are {g,f,e,d,c,b,a}, active low.
package seg7_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;
   localparam seg_t SEG_DASH  = 7'b0111111;

   localparam seg_t SEG_DIGIT [0:9] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000   // 9
   };

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-glyph decoder; non-decimal codes show a dash.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] code,
   output seg_t       seg
);

   always_comb begin
      seg = SEG_DASH;
      case (code)
         4'd0: seg = SEG_DIGIT[0];
         4'd1: seg = SEG_DIGIT[1];
         4'd2: seg = SEG_DIGIT[2];
         4'd3: seg = SEG_DIGIT[3];
         4'd4: seg = SEG_DIGIT[4];
         4'd5: seg = SEG_DIGIT[5];
         4'd6: seg = SEG_DIGIT[6];
         4'd7: seg = SEG_DIGIT[7];
         4'd8: seg = SEG_DIGIT[8];
         4'd9: seg = SEG_DIGIT[9];
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode display driver. New values are double-buffered
// and only committed at a scan-frame boundary so a frame never mixes values.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   output logic [NUM_DIGITS-1:0]   an,
   output seg_t                    seg,
   output logic                    dp,
   output logic                    pending,
   output logic                    updated
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = $clog2(NUM_DIGITS);

   logic [CNT_W-1:0]          cnt_reg;
   logic [IDX_W-1:0]          idx_reg;
   logic [4*NUM_DIGITS-1:0]   shadow_bcd_reg, active_bcd_reg;
   logic [NUM_DIGITS-1:0]     shadow_dp_reg, active_dp_reg;
   logic                      pending_reg, updated_reg;
   logic [NUM_DIGITS-1:0]     an_reg, an_next;
   seg_t                      seg_reg, seg_next;
   logic                      dp_reg, dp_next;

   logic                      tick, frame_end, commit, blank;
   seg_t                      digit_seg [NUM_DIGITS];
   // zero_from[i]: active digits i..NUM_DIGITS-1 are all zero
   logic [NUM_DIGITS-1:0]     zero_from;

   assign tick      = (cnt_reg == CNT_W'(REFRESH_DIV - 1));
   assign frame_end = tick && (idx_reg == IDX_W'(NUM_DIGITS - 1));
   assign commit    = frame_end && pending_reg;

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         seg7_decode u_decode (
            .code (active_bcd_reg[4*gi +: 4]),
            .seg  (digit_seg[gi])
         );
         if (gi == NUM_DIGITS - 1) begin : g_top
            assign zero_from[gi] = (active_bcd_reg[4*gi +: 4] == 4'd0);
         end else begin : g_lower
            assign zero_from[gi] = (active_bcd_reg[4*gi +: 4] == 4'd0) && zero_from[gi+1];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
         idx_reg <= '0;
      end else begin
         cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
         if (tick)
            idx_reg <= (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
      end
   end

   // A load coinciding with a commit keeps pending set so it lands next frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_bcd_reg <= '0;
         shadow_dp_reg  <= '0;
         active_bcd_reg <= '0;
         active_dp_reg  <= '0;
         pending_reg    <= 1'b0;
         updated_reg    <= 1'b0;
      end else begin
         updated_reg <= commit;
         if (commit) begin
            active_bcd_reg <= shadow_bcd_reg;
            active_dp_reg  <= shadow_dp_reg;
         end
         if (load) begin
            shadow_bcd_reg <= bcd_in;
            shadow_dp_reg  <= dp_in;
            pending_reg    <= 1'b1;
         end else if (commit) begin
            pending_reg    <= 1'b0;
         end
      end
   end

   always_comb begin
      an_next          = '1;
      an_next[idx_reg] = 1'b0;
      blank            = blank_lz && (idx_reg != '0) && zero_from[idx_reg];
      seg_next         = blank ? SEG_BLANK : digit_seg[idx_reg];
      dp_next          = ~active_dp_reg[idx_reg];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an_reg  <= '1;
         seg_reg <= SEG_BLANK;
         dp_reg  <= 1'b1;
      end else begin
         an_reg  <= an_next;
         seg_reg <= seg_next;
         dp_reg  <= dp_next;
      end
   end

   assign an      = an_reg;
   assign seg     = seg_reg;
   assign dp      = dp_reg;
   assign pending = pending_reg;
   assign updated = updated_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a time-based reference model.
module tb_seg7_scan_driver;

   localparam int N   = 4;
   localparam int DIV = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           load;
   logic [4*N-1:0] bcd_in;
   logic [N-1:0]   dp_in;
   logic           blank_lz;
   logic [N-1:0]   an;
   logic [6:0]     seg;
   logic           dp;
   logic           pending;
   logic           updated;

   int n_tests = 0;
   int n_fail  = 0;

   seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .bcd_in   (bcd_in),
      .dp_in    (dp_in),
      .blank_lz (blank_lz),
      .an       (an),
      .seg      (seg),
      .dp       (dp),
      .pending  (pending),
      .updated  (updated)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] glyph(input logic [3:0] c);
      case (c)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   // Model: edge k after reset shows digit (k/DIV)%N; a frame ends on edge k%(DIV*N)==DIV*N-1.
   int             ncnt;
   logic [4*N-1:0] m_sh_bcd, m_act_bcd;
   logic [N-1:0]   m_sh_dp, m_act_dp;
   logic           m_pend;
   logic [N-1:0]   e_an;
   logic [6:0]     e_seg;
   logic           e_dp, e_pend, e_upd;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ncnt <= 0; m_sh_bcd <= '0; m_act_bcd <= '0; m_sh_dp <= '0; m_act_dp <= '0;
         m_pend <= 1'b0; e_an <= '1; e_seg <= 7'h7F; e_dp <= 1'b1; e_pend <= 1'b0; e_upd <= 1'b0;
      end else begin : model_step
         int         d;
         bit         cmt;
         logic [N-1:0] a;
         d   = (ncnt / DIV) % N;
         cmt = ((ncnt % (DIV*N)) == DIV*N - 1) && m_pend;
         a = '1; a[d] = 1'b0;
         e_an  <= a;
         e_seg <= (blank_lz && d > 0 && (m_act_bcd >> (4*d)) == 0) ? 7'h7F : glyph(m_act_bcd[4*d +: 4]);
         e_dp  <= ~m_act_dp[d];
         e_upd <= cmt;
         if (cmt) begin
            m_act_bcd <= m_sh_bcd;
            m_act_dp  <= m_sh_dp;
         end
         if (load) begin
            m_sh_bcd <= bcd_in; m_sh_dp <= dp_in; m_pend <= 1'b1; e_pend <= 1'b1;
         end else begin
            m_pend <= cmt ? 1'b0 : m_pend;
            e_pend <= cmt ? 1'b0 : m_pend;
         end
         ncnt <= ncnt + 1;
      end
   end

   always @(negedge clk) begin
      check("an",      16'(an),      16'(e_an));
      check("seg",     16'(seg),     16'(e_seg));
      check("dp",      16'(dp),      16'(e_dp));
      check("pending", 16'(pending), 16'(e_pend));
      check("updated", 16'(updated), 16'(e_upd));
   end

   task automatic wait_digit(input int d);
      logic [N-1:0] want;
      bit ok;
      want = '1; want[d] = 1'b0; ok = 0;
      for (int k = 0; k < 64 && !ok; k++) begin
         @(negedge clk);
         if (an === want) ok = 1;
      end
      if (!ok) check("wait_digit_timeout", 16'(an), 16'(want));
   endtask

   task automatic wait_updated();
      bit ok;
      ok = 0;
      for (int k = 0; k < 64 && !ok; k++) begin
         @(negedge clk);
         if (updated === 1'b1) ok = 1;
      end
      check("updated_seen", 16'(ok), 16'd1);
   endtask

   task automatic wait_phase(input int p);
      bit ok;
      ok = 0;
      for (int k = 0; k < 64 && !ok; k++) begin
         @(negedge clk);
         if ((ncnt % (DIV*N)) == p) ok = 1;
      end
      if (!ok) check("wait_phase_timeout", 16'(ncnt % (DIV*N)), 16'(p));
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      load = 1'b1; bcd_in = v; dp_in = d;
      @(negedge clk);
      load = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; load = 1'b0; bcd_in = '0; dp_in = '0; blank_lz = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_an", 16'(an), 16'hF);
      check("reset_seg", 16'(seg), 16'h7F);
      reset = 1'b0;
      @(negedge clk);
      check("first_an", 16'(an), 16'b1110);
      check("first_seg", 16'(seg), 16'b1000000);
      repeat (20) @(negedge clk);

      // mid-frame load, no blanking
      wait_digit(1);
      do_load(16'h0015, 4'b0000);
      check("pending_after_load", 16'(pending), 16'd1);
      wait_updated();
      check("pending_after_commit", 16'(pending), 16'd0);
      wait_digit(0); check("d0_5", 16'(seg), 16'b0010010);
      wait_digit(1); check("d1_1", 16'(seg), 16'b1111001);
      wait_digit(2); check("d2_0", 16'(seg), 16'b1000000);
      wait_digit(3); check("d3_0", 16'(seg), 16'b1000000);

      // leading-zero blanking of the same value
      blank_lz = 1'b1;
      wait_digit(0); check("lz_d0", 16'(seg), 16'b0010010);
      wait_digit(1); check("lz_d1", 16'(seg), 16'b1111001);
      wait_digit(2); check("lz_d2", 16'(seg), 16'h7F);
      wait_digit(3); check("lz_d3", 16'(seg), 16'h7F);

      do_load(16'h0000, 4'b0000);
      wait_updated();
      wait_digit(0); check("zero_d0", 16'(seg), 16'b1000000);
      wait_digit(1); check("zero_d1", 16'(seg), 16'h7F);
      wait_digit(3); check("zero_d3", 16'(seg), 16'h7F);

      // load landing exactly on the frame_end edge
      blank_lz = 1'b0;
      wait_phase(5);
      do_load(16'h1234, 4'b0000);
      wait_phase(DIV*N - 1);
      do_load(16'h5678, 4'b0001);
      check("fe_updated", 16'(updated), 16'd1);
      check("fe_pending", 16'(pending), 16'd1);
      wait_digit(0); check("fe_d0_old", 16'(seg), 16'b0011001);
      wait_updated();
      check("fe2_pending", 16'(pending), 16'd0);
      wait_digit(0); check("fe2_d0", 16'(seg), 16'b0000000);
      check("fe2_dp0", 16'(dp), 16'd0);

      // dash codes and decimal point
      do_load(16'hA9F0, 4'b0100);
      wait_updated();
      wait_digit(0); check("a9f0_d0", 16'(seg), 16'b1000000); check("a9f0_dp0", 16'(dp), 16'd1);
      wait_digit(1); check("a9f0_d1", 16'(seg), 16'b0111111);
      wait_digit(2); check("a9f0_d2", 16'(seg), 16'b0010000); check("a9f0_dp2", 16'(dp), 16'd0);
      wait_digit(3); check("a9f0_d3", 16'(seg), 16'b0111111);

      // asynchronous reset mid-scan
      wait_digit(2);
      reset = 1'b1;
      #1;
      check("async_an", 16'(an), 16'hF);
      check("async_seg", 16'(seg), 16'h7F);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("restart_an", 16'(an), 16'b1110);
      check("restart_seg", 16'(seg), 16'b1000000);
      wait_digit(2); check("restart_d2", 16'(seg), 16'b1000000);
      check("restart_dp2", 16'(dp), 16'd1);
      repeat (8) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
